// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the cache-to-memory line arbiter.
package tartaruga_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_LINE_W = 128;
  localparam int unsigned LINE_BYTES = DEF_LINE_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_REQ      = 2'd1,
    ARB_WAIT_RSP = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  we;
    logic [DEF_LINE_W-1:0] data;
  } mem_line_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational two-way round-robin: on a tie the port not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant selection
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache (port 0) and D-cache
// (port 1); one outstanding transaction, round-robin between the ports.
module mem_arbiter
  import tartaruga_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  c_req_valid_i,
  output logic [1:0]                  c_req_ready_o,
  input  logic [1:0][ADDR_W-1:0]      c_addr_i,
  input  logic [1:0]                  c_we_i,
  input  logic [1:0][LINE_W-1:0]      c_data_wr_i,
  output logic [1:0]                  c_rsp_valid_o,
  input  logic [1:0]                  c_rsp_ready_i,
  output logic [LINE_W-1:0]           c_rsp_data_o,
  output logic [ADDR_W-1:0]           c_rsp_addr_o,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_we_o,
  output logic [LINE_W-1:0]           mem_data_wr_o,
  input  logic                        mem_rsp_valid_i,
  output logic                        mem_rsp_ready_o,
  input  logic [LINE_W-1:0]           mem_data_line_i,
  input  logic [ADDR_W-1:0]           mem_rsp_addr_i,
  output logic                        err_o
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_W / 8 - 1));

  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          arb_req_s;
  logic [1:0]          gnt_s;
  logic                gnt_idx_s;

  // Requests are only considered in IDLE and never while reset is asserted.
  assign arb_req_s = ((state_q == ARB_IDLE) && !rst_i) ? c_req_valid_i : 2'b00;

  rr_arbiter2 u_rr (
    .req_i  (arb_req_s),
    .last_i (last_q),
    .gnt_o  (gnt_s)
  );

  assign gnt_idx_s     = gnt_s[1];
  assign c_req_ready_o = gnt_s;
  assign mem_addr_o    = addr_q;
  assign mem_we_o      = we_q;
  assign mem_data_wr_o = wdata_q;

  // Next-state, latch updates and state-decoded handshake outputs
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_d          = last_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    err_o           = 1'b0;
    c_rsp_valid_o   = 2'b00;
    c_rsp_data_o    = {LINE_W{1'b0}};
    c_rsp_addr_o    = {ADDR_W{1'b0}};
    case (state_q)
      ARB_IDLE: begin
        if (gnt_s != 2'b00) begin
          owner_d = gnt_idx_s;
          we_d    = c_we_i[gnt_idx_s];
          addr_d  = c_addr_i[gnt_idx_s] & LINE_MASK;
          wdata_d = c_data_wr_i[gnt_idx_s];
          state_d = ARB_REQ;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = ARB_WAIT_RSP;
        end else begin
          state_d = ARB_REQ;
        end
      end
      ARB_WAIT_RSP: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i && (mem_rsp_addr_i == addr_q)) begin
          rdata_d = mem_data_line_i;
          state_d = ARB_RESP;
        end else if (mem_rsp_valid_i) begin
          // Stale or foreign response: consumed and dropped
          err_o   = 1'b1;
          state_d = ARB_WAIT_RSP;
        end else begin
          state_d = ARB_WAIT_RSP;
        end
      end
      ARB_RESP: begin
        c_rsp_valid_o[owner_q] = 1'b1;
        c_rsp_data_o           = we_q ? wdata_q : rdata_q;
        c_rsp_addr_o           = addr_q;
        if (c_rsp_ready_i[owner_q]) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_RESP;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and transaction latches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {LINE_W{1'b0}};
      rdata_q <= {LINE_W{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        c_req_valid;
  logic [1:0]        c_req_ready;
  logic [1:0][31:0]  c_addr;
  logic [1:0]        c_we;
  logic [1:0][127:0] c_data_wr;
  logic [1:0]        c_rsp_valid;
  logic [1:0]        c_rsp_ready;
  logic [127:0]      c_rsp_data;
  logic [31:0]       c_rsp_addr;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [127:0]      mem_data_wr;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [127:0]      mem_data_line;
  logic [31:0]       mem_rsp_addr;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] LINE_BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] LINE_A5   = {16{8'hA5}};
  localparam logic [127:0] LINE_JUNK = 128'h11112222_33334444_55556666_77778888;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .c_req_valid_i   (c_req_valid),
    .c_req_ready_o   (c_req_ready),
    .c_addr_i        (c_addr),
    .c_we_i          (c_we),
    .c_data_wr_i     (c_data_wr),
    .c_rsp_valid_o   (c_rsp_valid),
    .c_rsp_ready_i   (c_rsp_ready),
    .c_rsp_data_o    (c_rsp_data),
    .c_rsp_addr_o    (c_rsp_addr),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_addr_o      (mem_addr),
    .mem_we_o        (mem_we),
    .mem_data_wr_o   (mem_data_wr),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_ready_o (mem_rsp_ready),
    .mem_data_line_i (mem_data_line),
    .mem_rsp_addr_i  (mem_rsp_addr),
    .err_o           (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_rdy"}, c_req_ready, 2'b00);
    chk({tag, "_mreq_v"}, mem_req_valid, 1'b0);
    chk({tag, "_mrsp_rdy"}, mem_rsp_ready, 1'b0);
    chk({tag, "_rsp_v"}, c_rsp_valid, 2'b00);
    chk({tag, "_rsp_data"}, c_rsp_data, 128'd0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  // Called at the negedge of the grant cycle; returns one cycle after the response is taken.
  task automatic complete_txn(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                              input logic [127:0] line, input logic [127:0] exp_rsp,
                              input logic [1:0] owner, input logic [1:0] valid_after);
    tick();
    c_req_valid   = valid_after;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_mreq_v"}, mem_req_valid, 1'b1);
    chk({tag, "_maddr"}, mem_addr, exp_addr);
    chk({tag, "_mwe"}, mem_we, exp_we);
    chk({tag, "_nogrant"}, c_req_ready, 2'b00);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = exp_addr;
    mem_data_line = line;
    @(negedge clk);
    chk({tag, "_mrsp_rdy"}, mem_rsp_ready, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    c_rsp_ready   = owner;
    @(negedge clk);
    chk({tag, "_rsp_v"}, c_rsp_valid, owner);
    chk({tag, "_rsp_data"}, c_rsp_data, exp_rsp);
    chk({tag, "_rsp_addr"}, c_rsp_addr, exp_addr);
    tick();
    c_rsp_ready = 2'b00;
  endtask

  initial begin
    rst           = 1'b1;
    c_req_valid   = 2'b00;
    c_addr        = '0;
    c_we          = 2'b00;
    c_data_wr     = '0;
    c_rsp_ready   = 2'b00;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_data_line = 128'd0;
    mem_rsp_addr  = 32'd0;
    do_reset();
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_maddr", mem_addr, 32'd0);

    // Single read from port 1, zero wait
    tick();
    c_req_valid = 2'b10;
    c_addr[1]   = 32'h0000_1234;
    @(negedge clk);
    chk("rd1_grant", c_req_ready, 2'b10);
    complete_txn("rd1", 32'h0000_1230, 1'b0, LINE_BEEF, LINE_BEEF, 2'b10, 2'b00);

    // Tie after reset: 1, then 0, then 1
    do_reset();
    c_req_valid = 2'b11;
    c_addr[0]   = 32'h0000_0104;
    c_addr[1]   = 32'h0000_0208;
    @(negedge clk);
    chk("tie_grant1", c_req_ready, 2'b10);
    complete_txn("tie1", 32'h0000_0200, 1'b0, LINE_JUNK, LINE_JUNK, 2'b10, 2'b11);
    @(negedge clk);
    chk("tie_grant0", c_req_ready, 2'b01);
    complete_txn("tie0", 32'h0000_0100, 1'b0, LINE_BEEF, LINE_BEEF, 2'b01, 2'b11);
    @(negedge clk);
    chk("tie_grant1b", c_req_ready, 2'b10);
    complete_txn("tie1b", 32'h0000_0200, 1'b0, LINE_A5, LINE_A5, 2'b10, 2'b00);

    // Port 0 write with request stalls, mismatch, and response backpressure
    tick();
    c_req_valid  = 2'b01;
    c_addr[0]    = 32'h0000_0040;
    c_we         = 2'b01;
    c_data_wr[0] = LINE_A5;
    @(negedge clk);
    chk("wr_grant", c_req_ready, 2'b01);
    tick();
    c_req_valid  = 2'b00;
    c_data_wr[0] = LINE_JUNK;
    c_addr[0]    = 32'h0000_0FF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_stall_v", mem_req_valid, 1'b1);
      chk("wr_stall_addr", mem_addr, 32'h0000_0040);
      chk("wr_stall_we", mem_we, 1'b1);
      chk("wr_stall_data", mem_data_wr, LINE_A5);
      tick();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("wr_req_v", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = 32'h0000_0050;
    mem_data_line = LINE_BEEF;
    @(negedge clk);
    chk("mis_err", err, 1'b1);
    tick();
    mem_rsp_addr  = 32'h0000_0040;
    mem_data_line = LINE_JUNK;
    @(negedge clk);
    chk("mis_still_wait", mem_rsp_ready, 1'b1);
    chk("mis_err_clear", err, 1'b0);
    chk("mis_no_rsp", c_rsp_valid, 2'b00);
    tick();
    mem_rsp_valid = 1'b0;
    c_rsp_ready   = 2'b10;
    c_req_valid   = 2'b10;
    c_addr[1]     = 32'h0000_2008;
    c_we          = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_v", c_rsp_valid, 2'b01);
      chk("bp_rsp_data", c_rsp_data, LINE_A5);
      chk("bp_rsp_addr", c_rsp_addr, 32'h0000_0040);
      chk("bp_nogrant", c_req_ready, 2'b00);
      tick();
    end
    c_rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_rsp_v_last", c_rsp_valid, 2'b01);
    tick();
    c_rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_grant1", c_req_ready, 2'b10);
    complete_txn("bp_rd1", 32'h0000_2000, 1'b0, LINE_BEEF, LINE_BEEF, 2'b10, 2'b00);

    // Reset while waiting for the memory response
    tick();
    c_req_valid = 2'b01;
    c_addr[0]   = 32'h0000_0300;
    @(negedge clk);
    chk("rw_grant", c_req_ready, 2'b01);
    tick();
    c_req_valid   = 2'b00;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", mem_rsp_ready, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rw_after_rst");
    chk("rw_maddr", mem_addr, 32'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = 32'h0000_0300;
    mem_data_line = LINE_JUNK;
    @(negedge clk);
    chk("rw_late_rdy", mem_rsp_ready, 1'b0);
    chk("rw_late_err", err, 1'b0);
    tick();
    mem_rsp_valid = 1'b0;
    c_req_valid   = 2'b10;
    c_addr[1]     = 32'h0000_0400;
    @(negedge clk);
    chk("rw_new_grant", c_req_ready, 2'b10);
    complete_txn("rw_new", 32'h0000_0400, 1'b0, LINE_A5, LINE_A5, 2'b10, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
